if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Parametrised instruction-fetch stage that replaces the fixed single-register fetch path.
- Owns the PC and issues sequential requests to a 1-cycle-latency synchronous instruction memory.
- Buffers returned instructions in a DEPTH-entry queue and presents them to decode over a valid/ready handshake.
- Supports branch/jump redirect with flush of queued and in-flight fetches; sits between the instruction memory and ID.

Parameters:
- ADDR_W, 16, PC and instruction-memory address width.
- DATA_W, 16, instruction width.
- DEPTH, 4, fetch-queue entries; minimum 2; need not be a power of two.
- PC_INC, 4, sequential PC increment.
- RESET_PC, 0, PC value after reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  ADDR_W  fetch address; equals current PC.
- imem_rdata  in  DATA_W  instruction; valid in the cycle after imem_req.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_target  in  ADDR_W  new PC when redirect_valid is high.
- out_valid  out  1  queue head holds an instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  DATA_W  head instruction.
- out_pc  out  ADDR_W  address of the head instruction.
- out_pc_next  out  ADDR_W  out_pc + PC_INC, modulo 2^ADDR_W.
- occupancy  out  clog2(DEPTH+1)  current queue count.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - PC = RESET_PC; queue empty; in-flight flag cleared.
  - imem_req = 0; out_valid = 0; occupancy = 0.
  - out_instr, out_pc and out_pc_next = 0.
  - First imem_req is issued in the first clock cycle after reset deasserts.
- Pop: out_valid && out_ready. The head advances at the clock edge.
- Issue rule: imem_req = !reset && !redirect_valid && (occupancy + inflight − pop) < DEPTH.
  - The pop term is a combinational path from out_ready to imem_req.
  - This term gives full throughput at DEPTH = 2.
- On issue:
  - PC <= PC + PC_INC, wrapping modulo 2^ADDR_W; e.g. 0xFFFC -> 0x0000 at ADDR_W = 16.
  - inflight <= 1 and req_pc <= PC; otherwise inflight <= 0.
- Response: in the cycle after issue, if inflight is set and not killed, push {imem_rdata, req_pc} at the edge ending that cycle.
  - Latency: request issued in cycle n gives out_valid in cycle n+2 when the queue is empty.
  - Push and pop in the same cycle: occupancy is unchanged and FIFO order is preserved.
- Overflow is impossible by construction of the issue rule; an assertion checks occupancy <= DEPTH.
- Empty queue: out_valid = 0; out_instr and out_pc hold their last values and are don't-care.
- Redirect (redirect_valid = 1 in cycle t):
  - At the edge ending t: PC <= redirect_target, queue cleared, occupancy = 0.
  - Any response returning in cycle t is discarded; the kill is implemented with an epoch bit.
  - No request is issued in cycle t.
  - A pop handshake in cycle t is legal; downstream discards that instruction under the same redirect.
  - First request to the target is issued in t+1; the target instruction is at the head with out_valid = 1 in t+3.
  - Back-to-back redirects: the last one wins; each flushes again.
- Fetch control has no explicit FSM. State is PC, inflight, epoch and the queue pointers.
  - Effective modes: RUN (issuing), THROTTLED (queue plus in-flight at DEPTH), REDIRECT (one-cycle flush).

Decomposition:
- Package if_pkg holds:
  - default constants IF_ADDR_W = 16, IF_DATA_W = 16, IF_PC_INC = 4, IF_RESET_PC = 0;
  - typedef fetch_entry_t {instr, pc}.
- One sub-module, fetch_fifo: a synchronous FIFO with parameters DEPTH and entry width.
  - Ports: push, pop and a synchronous flush (flush has priority over push).
  - Outputs: count, empty, full.
  - It uses the same asynchronous active-high reset.

Test Plan:
- Reset then stream with out_ready = 1 and imem_rdata = address:
  - imem_addr runs 0, 4, 8, … every cycle;
  - out_valid first rises 2 cycles after the first request;
  - out_pc / out_instr follow 0/0, 4/4, … with no bubbles.
- Back-pressure with DEPTH = 4 and out_ready = 0:
  - occupancy reaches 4, then imem_req stays 0;
  - after out_ready rises, one pop per cycle resumes with no lost or duplicated PCs.
- Redirect to 0x0100 while one fetch is in flight and 3 entries are queued:
  - the next cycle has occupancy = 0;
  - the stale response is not pushed;
  - next imem_addr = 0x0100, then out_pc = 0x0100 with out_pc_next = 0x0104.
- Redirect and pop in the same cycle with a full queue:
  - queue empty afterwards;
  - no overflow assertion fires;
  - fetch resumes at the target.
- Wrap-around with RESET_PC = 0xFFF8: imem_addr sequence is 0xFFF8, 0xFFFC, 0x0000, 0x0004.
- Reset asserted mid-stream with occupancy = 3:
  - outputs go to their reset values immediately, without waiting for a clock edge;
  - after deassertion, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_pkg;

    localparam int IF_ADDR_W   = 16;
    localparam int IF_DATA_W   = 16;
    localparam int IF_PC_INC   = 4;
    localparam int IF_RESET_PC = 0;

    typedef struct packed {
        logic [IF_DATA_W-1:0] instr;
        logic [IF_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// Synchronous FIFO of DEPTH entries (any DEPTH >= 2) with a flush that beats push.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_push  = push && !flush;
        do_pop   = pop && !empty && !flush;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (count_q <= CNT_W'(DEPTH));
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: owns the PC, issues sequential fetches to a 1-cycle memory and
// queues the returned instructions for decode; redirects flush everything in flight.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int ADDR_W   = IF_ADDR_W,
    parameter int DATA_W   = IF_DATA_W,
    parameter int DEPTH    = 4,
    parameter int PC_INC   = IF_PC_INC,
    parameter int RESET_PC = IF_RESET_PC
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [DATA_W-1:0]          imem_rdata,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_target,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [ADDR_W-1:0]          out_pc_next,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam int ENTRY_W = DATA_W + ADDR_W;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic               inflight_q, inflight_d;
    logic               epoch_q, epoch_d;
    logic               req_epoch_q, req_epoch_d;
    logic               pop, push, issue;
    logic [CNT_W:0]     pending;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               fifo_empty, fifo_full;

    // Counting the same-cycle pop lets a DEPTH=2 queue sustain one fetch per cycle.
    always_comb begin
        pop     = out_valid && out_ready;
        push    = inflight_q && (req_epoch_q == epoch_q) && !redirect_valid;
        pending = {1'b0, occupancy} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
        issue   = !reset && !redirect_valid && (pending < (CNT_W+1)'(DEPTH));
    end

    always_comb begin
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        inflight_d  = issue;
        epoch_d     = epoch_q;
        req_epoch_d = req_epoch_q;
        if (redirect_valid) begin
            pc_d    = redirect_target;
            epoch_d = !epoch_q;
        end else if (issue) begin
            pc_d        = pc_q + ADDR_W'(PC_INC);
            req_pc_d    = pc_q;
            req_epoch_d = epoch_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q        <= ADDR_W'(RESET_PC);
            req_pc_q    <= '0;
            inflight_q  <= 1'b0;
            epoch_q     <= 1'b0;
            req_epoch_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            inflight_q  <= inflight_d;
            epoch_q     <= epoch_d;
            req_epoch_q <= req_epoch_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({imem_rdata, req_pc_q}),
        .rdata (fifo_rdata),
        .count (occupancy),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(fifo_full && push && !pop));
        end
    end

    assign imem_req    = issue;
    assign imem_addr   = pc_q;
    assign out_valid   = !fifo_empty;
    assign out_instr   = fifo_rdata[ENTRY_W-1:ADDR_W];
    assign out_pc      = fifo_rdata[ADDR_W-1:0];
    // Forced to zero while empty so the whole output bundle reads zero in reset.
    assign out_pc_next = out_valid ? (out_pc + ADDR_W'(PC_INC)) : '0;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: streaming, back-pressure, redirects,
// PC wrap-around and asynchronous mid-stream reset.
module tb_if_fetch_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_target = '0;
    logic        out_ready = 1'b0;
    logic [15:0] imem_rdata = '0;

    logic        imem_req, out_valid;
    logic [15:0] imem_addr, out_instr, out_pc, out_pc_next;
    logic [2:0]  occupancy;

    logic        w_imem_req, w_out_valid;
    logic [15:0] w_imem_addr, w_out_instr, w_out_pc, w_out_pc_next;
    logic [1:0]  w_occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // Instruction memory model: returns the requested address one cycle later.
    always @(posedge clock) imem_rdata <= imem_addr;

    if_fetch_queue #(.DEPTH(4)) u_dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pc_next(out_pc_next), .occupancy(occupancy)
    );

    if_fetch_queue #(.DEPTH(3), .RESET_PC(16'hFFF8)) u_wrap (
        .clock(clock), .reset(reset),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_instr(w_out_instr),
        .out_pc(w_out_pc), .out_pc_next(w_out_pc_next), .occupancy(w_occupancy)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        #1;
        checks++;
        if ({imem_req, out_valid, occupancy, out_instr, out_pc, out_pc_next} !== 52'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got req=%b valid=%b occ=%0d instr=%h pc=%h next=%h, expected all zero",
                     imem_req, out_valid, occupancy, out_instr, out_pc, out_pc_next);
        end
        checks++;
        if (w_imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_wrap_req: got %b expected 0", w_imem_req);
        end
        tick();
    endtask

    task automatic test_stream();
        logic [15:0] e;
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            e = 16'(4 * i);
            checks++;
            if ({imem_req, imem_addr} !== {1'b1, e}) begin
                errors++;
                $display("[TB] FAIL stream_req[%0d]: got req=%b addr=%h expected req=1 addr=%h", i, imem_req, imem_addr, e);
            end
            if (i < 2) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL stream_latency[%0d]: got valid=%b expected 0", i, out_valid);
                end
            end else begin
                e = 16'(4 * (i - 2));
                checks++;
                if ({out_valid, out_pc, out_instr, out_pc_next} !== {1'b1, e, e, 16'(e + 16'd4)}) begin
                    errors++;
                    $display("[TB] FAIL stream_head[%0d]: got valid=%b pc=%h instr=%h next=%h expected 1 %h %h %h",
                             i, out_valid, out_pc, out_instr, out_pc_next, e, e, 16'(e + 16'd4));
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] e;
        out_ready = 1'b0;
        repeat (6) tick();
        #1;
        checks++;
        if ({occupancy, imem_req, out_valid, out_pc} !== {3'd4, 1'b0, 1'b1, 16'd32}) begin
            errors++;
            $display("[TB] FAIL bp_full: got occ=%0d req=%b valid=%b pc=%h expected 4 0 1 0020",
                     occupancy, imem_req, out_valid, out_pc);
        end
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            e = 16'(32 + 4 * i);
            checks++;
            if ({out_valid, out_pc, out_instr} !== {1'b1, e, e}) begin
                errors++;
                $display("[TB] FAIL bp_drain[%0d]: got valid=%b pc=%h instr=%h expected 1 %h %h", i, out_valid, out_pc, out_instr, e, e);
            end
            e = 16'(48 + 4 * i);
            checks++;
            if ({imem_req, imem_addr} !== {1'b1, e}) begin
                errors++;
                $display("[TB] FAIL bp_resume[%0d]: got req=%b addr=%h expected 1 %h", i, imem_req, imem_addr, e);
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        #1;
        checks++;
        if ({occupancy, out_pc} !== {3'd3, 16'd64}) begin
            errors++;
            $display("[TB] FAIL redir_premise: got occ=%0d pc=%h expected 3 0040", occupancy, out_pc);
        end
        redirect_valid  = 1'b1;
        redirect_target = 16'h0100;
        out_ready       = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL redir_no_issue: got req=%b expected 0", imem_req);
        end
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        #1;
        checks++;
        if ({occupancy, out_valid, imem_req, imem_addr} !== {3'd0, 1'b0, 1'b1, 16'h0100}) begin
            errors++;
            $display("[TB] FAIL redir_flush: got occ=%0d valid=%b req=%b addr=%h expected 0 0 1 0100",
                     occupancy, out_valid, imem_req, imem_addr);
        end
        tick();
        #1;
        checks++;
        if ({out_valid, imem_addr} !== {1'b0, 16'h0104}) begin
            errors++;
            $display("[TB] FAIL redir_stale: got valid=%b addr=%h expected 0 0104", out_valid, imem_addr);
        end
        tick();
        #1;
        checks++;
        if ({out_valid, out_pc, out_instr, out_pc_next} !== {1'b1, 16'h0100, 16'h0100, 16'h0104}) begin
            errors++;
            $display("[TB] FAIL redir_target: got valid=%b pc=%h instr=%h next=%h expected 1 0100 0100 0104",
                     out_valid, out_pc, out_instr, out_pc_next);
        end
        tick();
        #1;
        checks++;
        if ({out_valid, out_pc} !== {1'b1, 16'h0104}) begin
            errors++;
            $display("[TB] FAIL redir_follow: got valid=%b pc=%h expected 1 0104", out_valid, out_pc);
        end
        tick();
    endtask

    task automatic test_redirect_pop_full();
        out_ready = 1'b0;
        repeat (6) tick();
        #1;
        checks++;
        if (occupancy !== 3'd4) begin
            errors++;
            $display("[TB] FAIL rpf_premise: got occ=%0d expected 4", occupancy);
        end
        redirect_valid  = 1'b1;
        redirect_target = 16'h0200;
        out_ready       = 1'b1;
        #1;
        checks++;
        if ({imem_req, out_valid} !== {1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL rpf_cycle: got req=%b valid=%b expected 0 1", imem_req, out_valid);
        end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if ({occupancy, out_valid, imem_req, imem_addr} !== {3'd0, 1'b0, 1'b1, 16'h0200}) begin
            errors++;
            $display("[TB] FAIL rpf_flush: got occ=%0d valid=%b req=%b addr=%h expected 0 0 1 0200",
                     occupancy, out_valid, imem_req, imem_addr);
        end
        tick();
        tick();
        #1;
        checks++;
        if ({out_valid, out_pc, out_pc_next} !== {1'b1, 16'h0200, 16'h0204}) begin
            errors++;
            $display("[TB] FAIL rpf_target: got valid=%b pc=%h next=%h expected 1 0200 0204", out_valid, out_pc, out_pc_next);
        end
        tick();
    endtask

    task automatic test_mid_reset_and_wrap();
        logic [15:0] e;
        out_ready = 1'b0;
        tick();
        tick();
        #1;
        checks++;
        if (occupancy !== 3'd3) begin
            errors++;
            $display("[TB] FAIL mr_premise: got occ=%0d expected 3", occupancy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({imem_req, out_valid, occupancy, out_instr, out_pc, out_pc_next, w_imem_req} !== 53'd0) begin
            errors++;
            $display("[TB] FAIL mr_async: got req=%b valid=%b occ=%0d instr=%h pc=%h next=%h wreq=%b expected all zero",
                     imem_req, out_valid, occupancy, out_instr, out_pc, out_pc_next, w_imem_req);
        end
        tick();
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            e = 16'(4 * i);
            checks++;
            if ({imem_req, imem_addr} !== {1'b1, e}) begin
                errors++;
                $display("[TB] FAIL mr_restart[%0d]: got req=%b addr=%h expected 1 %h", i, imem_req, imem_addr, e);
            end
            e = 16'(16'hFFF8 + 16'(4 * i));
            checks++;
            if ({w_imem_req, w_imem_addr} !== {1'b1, e}) begin
                errors++;
                $display("[TB] FAIL wrap_addr[%0d]: got req=%b addr=%h expected 1 %h", i, w_imem_req, w_imem_addr, e);
            end
            if (i >= 2) begin
                e = 16'(4 * (i - 2));
                checks++;
                if ({out_valid, out_pc, out_instr} !== {1'b1, e, e}) begin
                    errors++;
                    $display("[TB] FAIL mr_head[%0d]: got valid=%b pc=%h instr=%h expected 1 %h %h", i, out_valid, out_pc, out_instr, e, e);
                end
                e = 16'(16'hFFF8 + 16'(4 * (i - 2)));
                checks++;
                if ({w_out_valid, w_out_pc, w_out_pc_next} !== {1'b1, e, 16'(e + 16'd4)}) begin
                    errors++;
                    $display("[TB] FAIL wrap_head[%0d]: got valid=%b pc=%h next=%h expected 1 %h %h",
                             i, w_out_valid, w_out_pc, w_out_pc_next, e, 16'(e + 16'd4));
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_pop_full();
        test_mid_reset_and_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
